// File: rtl/alu_div_ctrl_pkg.sv
// Shared encodings for the RV32M divide sequencer: op codes, FSM states, iteration count.
// Pure declarations; no timing or flow-control behaviour of its own.
package alu_div_ctrl_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_div_ctrl_abs_neg.sv
// Conditional two's-complement negate; combinational, zero latency.
// No flow control: output follows inputs every cycle.
module alu_div_ctrl_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/alu_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer driving the shared ALU; 34 cycles accept->valid, 1 for special cases.
// No queueing: start_i is only taken in IDLE, requester holds it until accepted; flush_i aborts.
module alu_div_ctrl
  import alu_div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [1:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic                      flush_i,
  output logic [DATA_WIDTH-1:0]     alu_op1_o,
  output logic [DATA_WIDTH-1:0]     alu_op2_o,
  input  logic [DATA_WIDTH-1:0]     alu_sub_i,
  input  logic                      alu_ltu_i,
  output logic                      busy_o,
  output logic                      result_valid_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o
);

  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e                state_q, state_d;
  div_op_e                   op_q, op_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] tag_q, tag_d, rd_q, rd_d;
  logic                      neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic                      busy_q, busy_d, valid_q, valid_d;

  div_op_e               op_in;
  logic                  in_signed, take, fix_neg;
  logic [DATA_WIDTH-1:0] abs_a, abs_b, shifted, fix_val, fix_res;

  assign op_in     = div_op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign shifted   = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
  // R[31] set means the shifted value exceeds 2^32 > D, so the wrapped sub is still the true difference
  assign take      = rem_q[DATA_WIDTH-1] | ~alu_ltu_i;
  assign fix_val   = op_is_rem(op_q) ? rem_q : quo_q;
  assign fix_neg   = op_is_signed(op_q) & (op_is_rem(op_q) ? neg_rem_q : neg_quo_q);

  alu_div_ctrl_abs_neg #(.WIDTH(DATA_WIDTH)) u_abs_a (
    .val_i (dividend_i),
    .neg_i (in_signed & dividend_i[DATA_WIDTH-1]),
    .val_o (abs_a)
  );

  alu_div_ctrl_abs_neg #(.WIDTH(DATA_WIDTH)) u_abs_b (
    .val_i (divisor_i),
    .neg_i (in_signed & divisor_i[DATA_WIDTH-1]),
    .val_o (abs_b)
  );

  alu_div_ctrl_abs_neg #(.WIDTH(DATA_WIDTH)) u_fix (
    .val_i (fix_val),
    .neg_i (fix_neg),
    .val_o (fix_res)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    tag_d     = tag_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d = op_in;
          if (divisor_i == '0) begin
            result_d = op_is_rem(op_in) ? dividend_i : '1;
            rd_d     = rd_i;
            state_d  = ST_DONE;
          end else if (in_signed && dividend_i == INT_MIN && divisor_i == '1) begin
            result_d = op_is_rem(op_in) ? '0 : INT_MIN;
            rd_d     = rd_i;
            state_d  = ST_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = abs_a;
            dvs_d     = abs_b;
            tag_d     = rd_i;
            neg_quo_d = dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1];
            neg_rem_d = dividend_i[DATA_WIDTH-1];
            cnt_d     = CNT_W'(DIV_ITER - 1);
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = take ? alu_sub_i : shifted;
        quo_d = {quo_q[DATA_WIDTH-2:0], take};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        rd_d     = tag_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An abort leaves the last delivered result and tag visible
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_d     = rd_q;
    end

    busy_d  = (state_d == ST_CALC) || (state_d == ST_FIX);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= DIV_OP_DIV;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign alu_op1_o      = (state_q == ST_CALC) ? shifted : '0;
  assign alu_op2_o      = (state_q == ST_CALC) ? dvs_q : '0;
  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign result_o       = result_q;
  assign rd_o           = rd_q;

endmodule
